// File: rtl/uart_tx_arbiter_if.sv
// Handshake bundle between NUM_REQ byte producers, the arbiter and uart_tx.
// req_lock exists only when UART_TX_ARBITER_LOCK_EN is defined.
interface uart_tx_arbiter_if #(
   parameter int NUM_REQ = 4
) ();
   localparam int IDW = $clog2(NUM_REQ);

   logic [NUM_REQ-1:0]   req_valid;
   logic [8*NUM_REQ-1:0] req_data;
   logic [NUM_REQ-1:0]   req_ready;
   logic                 uart_tx_start;
   logic [7:0]           uart_tx_data;
   logic                 uart_tx_busy;
   logic [IDW-1:0]       grant_id;
   logic                 active;
   logic                 err_timeout;
`ifdef UART_TX_ARBITER_LOCK_EN
   logic [NUM_REQ-1:0]   req_lock;
`endif

   // master: requesters plus transmitter side; slave: the arbiter
   modport master (
`ifdef UART_TX_ARBITER_LOCK_EN
      output req_lock,
`endif
      output req_valid, req_data, uart_tx_busy,
      input  req_ready, uart_tx_start, uart_tx_data, grant_id, active, err_timeout
   );

   modport slave (
`ifdef UART_TX_ARBITER_LOCK_EN
      input  req_lock,
`endif
      input  req_valid, req_data, uart_tx_busy,
      output req_ready, uart_tx_start, uart_tx_data, grant_id, active, err_timeout
   );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx between NUM_REQ byte producers.
// Optional UART_TX_ARBITER_LOCK_EN adds per-requester lock for unbroken packets.
//
// state       | meaning
// S_IDLE      | waiting for a valid request with transmitter not busy
// S_ISSUE     | byte latched, start pulse issued on the exit edge
// S_WAIT_BUSY | waiting for uart_tx_busy to rise, timeout counter running
// S_WAIT_DONE | frame in flight, waiting for uart_tx_busy to fall
module uart_tx_arbiter #(
   parameter int NUM_REQ      = 4,
   parameter int BUSY_TIMEOUT = 16
) (
   input logic             clk,
   input logic             rst_n,
   uart_tx_arbiter_if.slave bus
);
   localparam int         IDW = $clog2(NUM_REQ);
   localparam logic [7:0] TIMEOUT_TC = 8'(BUSY_TIMEOUT);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT_BUSY,
      S_WAIT_DONE
   } state_t;

   state_t               state_q, state_d;
   logic [IDW-1:0]       ptr_q, ptr_d;
   logic [IDW-1:0]       grant_q, grant_d;
   logic [7:0]           cnt_q, cnt_d;
   logic [7:0]           data_q, data_d;
   logic [NUM_REQ-1:0]   ready_q, ready_d;
   logic                 start_q, start_d;
   logic                 active_q, active_d;
   logic                 err_q, err_d;

   logic                 found;
   logic [IDW-1:0]       win;
   logic [IDW-1:0]       next_grant;
   logic                 lock_hold;

`ifdef UART_TX_ARBITER_LOCK_EN
   assign lock_hold = bus.req_lock[grant_q];
`else
   assign lock_hold = 1'b0;
`endif

   assign next_grant = (grant_q == IDW'(NUM_REQ - 1)) ? '0 : grant_q + IDW'(1);

   // first valid requester at or after the pointer, wrapping
   always_comb begin
      int idx;
      found = 1'b0;
      win   = '0;
      idx   = 0;
      for (int i = 0; i < NUM_REQ; i++) begin
         idx = int'(ptr_q) + i;
         if (idx >= NUM_REQ) begin
            idx = idx - NUM_REQ;
         end
         if (!found && bus.req_valid[idx]) begin
            found = 1'b1;
            win   = IDW'(idx);
         end
      end
   end

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      grant_d = grant_q;
      cnt_d   = cnt_q;
      data_d  = data_q;
      ready_d = '0;
      start_d = 1'b0;
      err_d   = err_q;

      case (state_q)
         S_IDLE: begin
            if (found && !bus.uart_tx_busy) begin
               ready_d[win] = 1'b1;
               data_d       = bus.req_data[8*win +: 8];
               grant_d      = win;
               state_d      = S_ISSUE;
            end
         end
         S_ISSUE: begin
            start_d = 1'b1;
            cnt_d   = '0;
            state_d = S_WAIT_BUSY;
         end
         S_WAIT_BUSY: begin
            if (bus.uart_tx_busy) begin
               state_d = S_WAIT_DONE;
            end else begin
               cnt_d = cnt_q + 8'd1;
               // a timeout never honours the lock, so a dead link cannot starve others
               if (cnt_d == TIMEOUT_TC) begin
                  err_d   = 1'b1;
                  ptr_d   = next_grant;
                  state_d = S_IDLE;
               end
            end
         end
         S_WAIT_DONE: begin
            if (!bus.uart_tx_busy) begin
               ptr_d   = lock_hold ? grant_q : next_grant;
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      active_d = (state_d != S_IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         ptr_q    <= '0;
         grant_q  <= '0;
         cnt_q    <= '0;
         data_q   <= '0;
         ready_q  <= '0;
         start_q  <= 1'b0;
         active_q <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         ptr_q    <= ptr_d;
         grant_q  <= grant_d;
         cnt_q    <= cnt_d;
         data_q   <= data_d;
         ready_q  <= ready_d;
         start_q  <= start_d;
         active_q <= active_d;
         err_q    <= err_d;
      end
   end

   assign bus.req_ready     = ready_q;
   assign bus.uart_tx_start = start_q;
   assign bus.uart_tx_data  = data_q;
   assign bus.grant_id      = grant_q;
   assign bus.active        = active_q;
   assign bus.err_timeout   = err_q;

endmodule
